unidade_acesso_memoria: RTL

Initiator-side load/store unit driving the byte-addressed, little-endian 16-bit data memory (`memoria_dados`) of the MIPS datapath. It accepts one load or store request at a time from the datapath and sequences the memory enables. Byte stores are performed as a read-modify-write, since the memory only writes whole 16-bit words. Each completed operation is reported with a one-cycle `concluido` pulse, and errors are flagged on the same cycle.

---
 rtl/unidade_acesso_memoria_pkg.sv | 30 +++
 rtl/unidade_acesso_memoria_alinhador_byte.sv | 22 ++
 rtl/unidade_acesso_memoria.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/unidade_acesso_memoria_pkg.sv
// Shared definitions for the MIPS data-memory load/store unit: opcodes,
// FSM state encoding and opcode classification helpers.
package pacote_memoria;

    localparam int LARGURA_PALAVRA = 16;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b011;
    localparam logic [2:0] OP_SB  = 3'b100;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        LEITURA     = 3'd1,
        ESCRITA     = 3'd2,
        RMW_LEITURA = 3'd3,
        RMW_ESCRITA = 3'd4,
        FIM         = 3'd5
    } estado_t;

    function automatic logic eh_carga(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic eh_op_byte(input logic [2:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/unidade_acesso_memoria_alinhador_byte.sv
// Byte lane handling for the load/store unit: extends the selected byte for
// LB/LBU and merges a store byte into a read word for SB.
module alinhador_byte
    import pacote_memoria::*;
(
    input  logic [LARGURA_PALAVRA-1:0] palavra_lida,
    input  logic                       seleciona_alto,
    input  logic                       com_sinal,
    input  logic [7:0]                 byte_escrita,
    output logic [LARGURA_PALAVRA-1:0] byte_estendido,
    output logic [LARGURA_PALAVRA-1:0] palavra_mesclada
);

    logic [7:0] byte_selecionado;

    // Little-endian: address bit 0 set picks the upper byte of the word.
    assign byte_selecionado = seleciona_alto ? palavra_lida[15:8] : palavra_lida[7:0];
    assign byte_estendido   = {{8{com_sinal & byte_selecionado[7]}}, byte_selecionado};
    assign palavra_mesclada = seleciona_alto ? {byte_escrita, palavra_lida[7:0]}
                                             : {palavra_lida[15:8], byte_escrita};

endmodule

// File: rtl/unidade_acesso_memoria.sv
// Load/store unit sequencing the 16-bit byte-addressed data memory; SB is a
// read-modify-write. Define ALIGN_CHECK_EN to reject misaligned LW/SW.
module unidade_acesso_memoria
    import pacote_memoria::*;
#(
    parameter int ENDERECO_MAX = 255
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req,
    input  logic [2:0]                 operacao,
    input  logic [15:0]                endereco,
    input  logic [LARGURA_PALAVRA-1:0] dado_escrita,
    output logic                       ocupado,
    output logic                       concluido,
    output logic                       erro,
    output logic [LARGURA_PALAVRA-1:0] dado_leitura,
    output logic                       mem_permisao_leitura,
    output logic                       mem_permisao_escrita,
    output logic [15:0]                mem_endereco,
    output logic [LARGURA_PALAVRA-1:0] mem_dado_escrita,
    input  logic [LARGURA_PALAVRA-1:0] mem_dado_leitura
);

    localparam logic [16:0] LIMITE_BYTE    = 17'(ENDERECO_MAX);
    localparam logic [16:0] LIMITE_PALAVRA = 17'(ENDERECO_MAX - 1);

    estado_t                      estado, proximo;
    logic                         aceita;
    logic                         erro_pedido;
    logic [2:0]                   operacao_reg;
    logic [15:0]                  endereco_reg;
    logic [LARGURA_PALAVRA-1:0]   dado_reg;
    logic [LARGURA_PALAVRA-1:0]   mesclada_reg;
    logic [LARGURA_PALAVRA-1:0]   byte_estendido;
    logic [LARGURA_PALAVRA-1:0]   palavra_mesclada;
    logic [15:0]                  endereco_acesso;
    logic                         escrita_interna;
    logic                         erro_reg;
    logic [LARGURA_PALAVRA-1:0]   dado_leitura_reg;

    assign aceita = (estado == OCIOSO) && req;

    always_comb begin
        erro_pedido = 1'b0;
        case (operacao)
            OP_LW, OP_SW: begin
                erro_pedido = ({1'b0, endereco} > LIMITE_PALAVRA);
`ifdef ALIGN_CHECK_EN
                erro_pedido = erro_pedido | endereco[0];
`endif
            end
            OP_LB, OP_LBU, OP_SB: erro_pedido = ({1'b0, endereco} > LIMITE_BYTE);
            default:              erro_pedido = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= proximo;
    end

    // NOTE: captured request fields carry no reset; the FSM never consumes
    // them until a request has loaded them.
    always_ff @(posedge clock) begin
        if (aceita) begin
            operacao_reg <= operacao;
            endereco_reg <= endereco;
            dado_reg     <= dado_escrita;
        end
        if (estado == RMW_LEITURA) mesclada_reg <= palavra_mesclada;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            erro_reg         <= 1'b0;
            dado_leitura_reg <= '0;
        end else if (aceita) begin
            erro_reg <= erro_pedido;
            if (erro_pedido && eh_carga(operacao)) dado_leitura_reg <= '0;
        end else if (estado == LEITURA) begin
            dado_leitura_reg <= (operacao_reg == OP_LW) ? mem_dado_leitura : byte_estendido;
        end
    end

    alinhador_byte u_alinhador (
        .palavra_lida     (mem_dado_leitura),
        .seleciona_alto   (endereco_reg[0]),
        .com_sinal        (operacao_reg == OP_LB),
        .byte_escrita     (dado_reg[7:0]),
        .byte_estendido   (byte_estendido),
        .palavra_mesclada (palavra_mesclada)
    );

    assign endereco_acesso = eh_op_byte(operacao_reg) ? {endereco_reg[15:1], 1'b0}
                                                      : endereco_reg;

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        proximo              = estado;
        mem_permisao_leitura = 1'b0;
        escrita_interna      = 1'b0;
        mem_endereco         = '0;
        mem_dado_escrita     = '0;
        case (estado)
            OCIOSO: begin
                if (req) begin
                    if (erro_pedido)            proximo = FIM;
                    else if (operacao == OP_SB) proximo = RMW_LEITURA;
                    else if (operacao == OP_SW) proximo = ESCRITA;
                    else                        proximo = LEITURA;
                end
            end
            LEITURA, RMW_LEITURA: begin
                mem_permisao_leitura = 1'b1;
                mem_endereco         = endereco_acesso;
                proximo              = (estado == LEITURA) ? FIM : RMW_ESCRITA;
            end
            ESCRITA: begin
                escrita_interna  = 1'b1;
                mem_endereco     = endereco_acesso;
                mem_dado_escrita = dado_reg;
                proximo          = FIM;
            end
            RMW_ESCRITA: begin
                escrita_interna  = 1'b1;
                mem_endereco     = endereco_acesso;
                mem_dado_escrita = mesclada_reg;
                proximo          = FIM;
            end
            FIM:     proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    // Write enable dropped combinationally so a reset edge never commits a write.
    assign mem_permisao_escrita = escrita_interna & ~reset;

    assign ocupado      = (estado != OCIOSO);
    assign concluido    = (estado == FIM);
    assign erro         = erro_reg;
    assign dado_leitura = dado_leitura_reg;

endmodule
